// File: rtl/leve_htif_pkg.sv
// Shared HTIF definitions: controller states, tohost field positions and
// the device/command codes recognised by the console path.
package leve_htif_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP,
    DONE
  } htif_state_t;

  localparam int unsigned EXIT_BIT = 0;
  localparam int unsigned DEV_MSB  = 31;
  localparam int unsigned DEV_LSB  = 24;
  localparam int unsigned CMD_MSB  = 23;
  localparam int unsigned CMD_LSB  = 16;

  localparam logic [7:0]  DEV_CONSOLE = 8'd1;
  localparam logic [7:0]  CMD_PUTCHAR = 8'd1;
  localparam logic [31:0] HTIF_ACK    = 32'h1;

endpackage

// File: rtl/htif_ctrl_watchdog.sv
// Saturating cycle counter with enable. It raises a combinational expire
// pulse when the count reaches limit-1. A limit of 0 never expires.
module htif_watchdog #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic             expire
);

  logic [CNT_W-1:0] cnt;

  // Count enabled cycles, holding at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expire = en && (limit != '0) && (cnt == limit - CNT_W'(1));

endmodule

// File: rtl/htif_ctrl.sv
// Host-target interface controller. Decodes tohost writes into exit or
// device requests, acknowledges device requests on fromhost after a fixed
// latency, and keeps sticky done/pass/timeout/proto_err verdicts.
// Optional console output is enabled by defining HTIF_CONSOLE_EN.
module htif_ctrl
  import leve_htif_pkg::*;
#(
  parameter int unsigned RESP_LAT       = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned CNT_W          = 32
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        tohost_we,
  input  logic [31:0] tohost,
  output logic        fromhost_we,
  output logic [31:0] fromhost,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [30:0] exit_code,
  output logic        proto_err,
  output logic        char_valid,
  output logic [7:0]  char_data
);

  htif_state_t      state, state_next;
  logic [CNT_W-1:0] rcnt;
  logic             accept_exit;
  logic             accept_dev;
  logic             expire;
  logic             wd_en;

  assign wd_en = (state != DONE);

  htif_watchdog #(
    .CNT_W(CNT_W)
  ) u_wdog (
    .clk    (CLK),
    .rst    (RST),
    .en     (wd_en),
    .limit  (CNT_W'(TIMEOUT_CYCLES)),
    .expire (expire)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; an exit write in the expiry cycle takes priority.
  always_comb begin
    state_next  = state;
    accept_exit = 1'b0;
    accept_dev  = 1'b0;
    case (state)
      IDLE: begin
        if (tohost_we && tohost[EXIT_BIT]) begin
          accept_exit = 1'b1;
          state_next  = DONE;
        end else if (tohost_we) begin
          accept_dev = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT:    if (rcnt == '0) state_next = RESP;
      RESP:    state_next = IDLE;
      DONE:    state_next = DONE;
      default: state_next = IDLE;
    endcase
    if (expire && !accept_exit) begin
      state_next = DONE;
    end
  end

  // Response latency counter and sticky verdict registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rcnt      <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
      timeout   <= 1'b0;
      exit_code <= '0;
      proto_err <= 1'b0;
    end else begin
      if (accept_dev) begin
        rcnt <= CNT_W'(RESP_LAT - 1);
      end else if ((state == WAIT) && (rcnt != '0)) begin
        rcnt <= rcnt - CNT_W'(1);
      end

      if (accept_exit) begin
        exit_code <= tohost[31:1];
        pass      <= (tohost[31:1] == '0);
        done      <= 1'b1;
      end else if (expire) begin
        timeout <= 1'b1;
        done    <= 1'b1;
        pass    <= 1'b0;
      end

      if (tohost_we && ((state == WAIT) || (state == RESP))) begin
        proto_err <= 1'b1;
      end
    end
  end

  assign fromhost_we = (state == RESP);
  assign fromhost    = (state == RESP) ? HTIF_ACK : '0;
  assign busy        = (state == WAIT);

`ifdef HTIF_CONSOLE_EN
  logic is_putchar;

  assign is_putchar = (tohost[DEV_MSB:DEV_LSB] == DEV_CONSOLE) &&
                      (tohost[CMD_MSB:CMD_LSB] == CMD_PUTCHAR);

  // One-cycle putchar strobe following acceptance; the byte is held.
  always_ff @(posedge CLK) begin
    if (RST) begin
      char_valid <= 1'b0;
      char_data  <= '0;
    end else begin
      char_valid <= accept_dev && is_putchar;
      if (accept_dev && is_putchar) begin
        char_data <= tohost[8:1];
      end
    end
  end
`else
  assign char_valid = 1'b0;
  assign char_data  = '0;
`endif

endmodule

// File: tb/tb_htif_ctrl.sv
// Self-checking bench for htif_ctrl: scoreboard queues hold the expected
// cycle of each fromhost acknowledge and putchar strobe.
module tb_htif_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        tohost_we = 1'b0;
  logic [31:0] tohost = '0;
  logic        fromhost_we;
  logic [31:0] fromhost;
  logic        busy, done, pass, timeout, proto_err, char_valid;
  logic [30:0] exit_code;
  logic [7:0]  char_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rel = 0;

  typedef struct {
    int         c;
    logic [7:0] d;
  } ch_t;

  int  ack_q[$];
  ch_t char_q[$];

  htif_ctrl #(
    .RESP_LAT       (4),
    .TIMEOUT_CYCLES (50),
    .CNT_W          (32)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .tohost_we   (tohost_we),
    .tohost      (tohost),
    .fromhost_we (fromhost_we),
    .fromhost    (fromhost),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .timeout     (timeout),
    .exit_code   (exit_code),
    .proto_err   (proto_err),
    .char_valid  (char_valid),
    .char_data   (char_data)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Acknowledge monitor.
  always @(negedge CLK) begin
    if (!RST && fromhost_we) begin
      checks++;
      if (ack_q.size() == 0) begin
        errors++;
        $display("FAIL ack_unexpected cyc=%0d fromhost=%h", cyc, fromhost);
      end else begin
        int e;
        e = ack_q.pop_front();
        if (e !== cyc || fromhost !== 32'h1) begin
          errors++;
          $display("FAIL ack_timing cyc=%0d exp_cyc=%0d fromhost=%h exp=00000001", cyc, e, fromhost);
        end
      end
    end
  end

`ifdef HTIF_CONSOLE_EN
  // Putchar monitor.
  always @(negedge CLK) begin
    if (!RST && char_valid) begin
      checks++;
      if (char_q.size() == 0) begin
        errors++;
        $display("FAIL char_unexpected cyc=%0d data=%h", cyc, char_data);
      end else begin
        ch_t e;
        e = char_q.pop_front();
        if (e.c !== cyc || e.d !== char_data) begin
          errors++;
          $display("FAIL char cyc=%0d data=%h exp_cyc=%0d exp_data=%h", cyc, char_data, e.c, e.d);
        end
      end
    end
  end
`else
  always @(negedge CLK) begin
    if (!RST) begin
      checks++;
      if (char_valid !== 1'b0 || char_data !== 8'h00) begin
        errors++;
        $display("FAIL char_tied valid=%b data=%h exp=0/00", char_valid, char_data);
      end
    end
  end
`endif

  task automatic exp_char(input logic [7:0] d);
`ifdef HTIF_CONSOLE_EN
    ch_t e;
    e.c = cyc + 1;
    e.d = d;
    char_q.push_back(e);
`else
    if (d === 8'hxx) $display("unused");
`endif
  endtask

  task automatic write_th(input logic [31:0] v);
    tohost_we = 1'b1;
    tohost    = v;
    @(negedge CLK);
    tohost_we = 1'b0;
    tohost    = '0;
  endtask

  task automatic do_reset();
    RST       = 1'b1;
    tohost_we = 1'b0;
    tohost    = '0;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    rel = cyc;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    checks++;
    if ({fromhost_we, fromhost, busy, done, pass, timeout, exit_code, proto_err,
         char_valid, char_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs we=%b fh=%h busy=%b done=%b pass=%b to=%b code=%h perr=%b cv=%b cd=%h exp=all0",
               fromhost_we, fromhost, busy, done, pass, timeout, exit_code, proto_err, char_valid, char_data);
    end
    RST = 1'b0;
  endtask

  task automatic test_exit_pass();
    do_reset();
    write_th(32'h0000_0001);
    checks++;
    if (done !== 1'b1 || pass !== 1'b1 || exit_code !== 31'h0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL exit_pass done=%b pass=%b code=%h to=%b exp=1/1/0/0", done, pass, exit_code, timeout);
    end
    repeat (8) @(negedge CLK);
    checks++;
    if (done !== 1'b1 || pass !== 1'b1) begin
      errors++;
      $display("FAIL exit_sticky done=%b pass=%b exp=1/1", done, pass);
    end
  endtask

  task automatic test_exit_fail();
    do_reset();
    write_th(32'h0000_0007);
    checks++;
    if (done !== 1'b1 || pass !== 1'b0 || exit_code !== 31'h3) begin
      errors++;
      $display("FAIL exit_fail done=%b pass=%b code=%h exp=1/0/3", done, pass, exit_code);
    end
  endtask

  task automatic test_putchar();
    do_reset();
    ack_q.push_back(cyc + 5);
    exp_char(8'h41);
    write_th(32'h0101_0082);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL putchar_busy busy=%b exp=1", busy);
    end
    for (int i = 0; i < 20 && ack_q.size() != 0; i++) @(negedge CLK);
    checks++;
    if (ack_q.size() != 0 || char_q.size() != 0) begin
      errors++;
      $display("FAIL putchar_drain acks_left=%0d chars_left=%0d exp=0/0", ack_q.size(), char_q.size());
    end
    @(negedge CLK);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || proto_err !== 1'b0) begin
      errors++;
      $display("FAIL putchar_idle busy=%b done=%b perr=%b exp=0/0/0", busy, done, proto_err);
    end
  endtask

  task automatic test_proto_err();
    do_reset();
    ack_q.push_back(cyc + 5);
    exp_char(8'h41);
    write_th(32'h0101_0082);
    @(negedge CLK);
    write_th(32'h0000_0001);
    checks++;
    if (proto_err !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL proto_err perr=%b done=%b exp=1/0", proto_err, done);
    end
    for (int i = 0; i < 20 && ack_q.size() != 0; i++) @(negedge CLK);
    repeat (6) @(negedge CLK);
    checks++;
    if (ack_q.size() != 0 || proto_err !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL proto_after acks_left=%0d perr=%b done=%b exp=0/1/0", ack_q.size(), proto_err, done);
    end
  endtask

  task automatic test_back_to_back();
    int w;
    do_reset();
    w = cyc;
    ack_q.push_back(w + 5);
    exp_char(8'h5a);
    write_th(32'h0101_00b4);
    while (cyc < w + 6) @(negedge CLK);
    ack_q.push_back(cyc + 5);
    write_th(32'h0203_0010);
    for (int i = 0; i < 20 && ack_q.size() != 0; i++) @(negedge CLK);
    checks++;
    if (ack_q.size() != 0 || char_q.size() != 0 || proto_err !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back acks_left=%0d chars_left=%0d perr=%b exp=0/0/0",
               ack_q.size(), char_q.size(), proto_err);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    exp_char(8'h41);
    write_th(32'h0101_0082);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    checks++;
    if ({fromhost_we, fromhost, busy, done, pass, timeout, exit_code, proto_err,
         char_valid, char_data} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs we=%b busy=%b done=%b perr=%b cv=%b cd=%h exp=all0",
               fromhost_we, busy, done, proto_err, char_valid, char_data);
    end
    RST = 1'b0;
    repeat (8) @(negedge CLK);
    ack_q.push_back(cyc + 5);
    exp_char(8'h2a);
    write_th(32'h0101_0054);
    for (int i = 0; i < 20 && ack_q.size() != 0; i++) @(negedge CLK);
    checks++;
    if (ack_q.size() != 0 || char_q.size() != 0) begin
      errors++;
      $display("FAIL reset_mid_new acks_left=%0d chars_left=%0d exp=0/0", ack_q.size(), char_q.size());
    end
  endtask

  task automatic test_timeout();
    do_reset();
    while (cyc < rel + 49) @(negedge CLK);
    checks++;
    if (done !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early done=%b to=%b exp=0/0", done, timeout);
    end
    @(negedge CLK);
    checks++;
    if (done !== 1'b1 || timeout !== 1'b1 || pass !== 1'b0) begin
      errors++;
      $display("FAIL timeout_fire done=%b to=%b pass=%b exp=1/1/0", done, timeout, pass);
    end
    write_th(32'h0000_0005);
    write_th(32'h0101_0082);
    repeat (8) @(negedge CLK);
    checks++;
    if (exit_code !== 31'h0 || pass !== 1'b0 || proto_err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_absorb code=%h pass=%b perr=%b busy=%b exp=0/0/0/0", exit_code, pass, proto_err, busy);
    end
  endtask

  task automatic test_timeout_abandon();
    do_reset();
    while (cyc < rel + 47) @(negedge CLK);
    exp_char(8'h41);
    write_th(32'h0101_0082);
    while (cyc < rel + 50) @(negedge CLK);
    checks++;
    if (done !== 1'b1 || timeout !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_abandon done=%b to=%b busy=%b exp=1/1/0", done, timeout, busy);
    end
    repeat (6) @(negedge CLK);
  endtask

  task automatic test_exit_wins();
    do_reset();
    while (cyc < rel + 49) @(negedge CLK);
    write_th(32'h0000_0001);
    checks++;
    if (done !== 1'b1 || pass !== 1'b1 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL exit_wins done=%b pass=%b to=%b exp=1/1/0", done, pass, timeout);
    end
    repeat (4) @(negedge CLK);
    checks++;
    if (timeout !== 1'b0 || pass !== 1'b1) begin
      errors++;
      $display("FAIL exit_wins_hold to=%b pass=%b exp=0/1", timeout, pass);
    end
  endtask

  initial begin
    @(negedge CLK);
    test_reset();
    test_exit_pass();
    test_exit_fail();
    test_putchar();
    test_proto_err();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    test_timeout_abandon();
    test_exit_wins();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "bench time limit expired");
  end

endmodule
